// File: rtl/entry_checker.sv
// Judges a completed 4-nibble entry against the current target: scores passes,
// counts misses, locks the player out after too many, and clears the entry register.
module entry_checker #(
    parameter int unsigned MAX_ATTEMPTS  = 3,
    parameter int unsigned LOCK_CYCLES   = 50,
    parameter int unsigned RESULT_CYCLES = 8,
    parameter int unsigned SCORE_W       = 8
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [15:0]        entered,
    input  logic               valid_bit,
    input  logic [15:0]        target,
    input  logic               target_valid,
    input  logic               log_out,
    output logic               match,
    output logic               mismatch,
    output logic [2:0]         digits_correct,
    output logic [2:0]         attempts_left,
    output logic               locked,
    output logic [SCORE_W-1:0] score,
    output logic               clear_entry,
    output logic               next_pattern
);

    localparam int unsigned TIMER_MAX = (LOCK_CYCLES > RESULT_CYCLES) ? LOCK_CYCLES : RESULT_CYCLES;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [2:0]         ATTEMPTS_FULL = 3'(MAX_ATTEMPTS);
    localparam logic [TIMER_W-1:0] RESULT_LOAD   = TIMER_W'(RESULT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LOAD     = TIMER_W'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        COMPARE = 3'd2,
        RESULT  = 3'd3,
        LOCK    = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;

    logic                 valid_q;
    logic                 rise_q;
    logic                 log_q;
    logic [15:0]          entry_q;
    logic [15:0]          target_q;
    logic [TIMER_W-1:0]   timer;

    logic [15:0]          entry_d;
    logic [15:0]          target_d;
    logic [TIMER_W-1:0]   timer_d;
    logic                 match_d;
    logic                 mismatch_d;
    logic [2:0]           digits_d;
    logic [2:0]           attempts_d;
    logic                 locked_d;
    logic [SCORE_W-1:0]   score_d;
    logic                 clear_req;
    logic                 next_d;

    logic                 timer_done_c;
    logic                 pass_c;
    logic [2:0]           hits_c;

    assign timer_done_c = (timer == '0);
    assign pass_c       = (entry_q == target_q);

    // Registered edge detect; a rise coinciding with log_out is discarded.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            rise_q  <= 1'b0;
            log_q   <= 1'b0;
        end else begin
            valid_q <= valid_bit;
            rise_q  <= valid_bit & ~valid_q & ~log_out;
            log_q   <= log_out;
        end
    end

    always_comb begin
        hits_c = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (entry_q[4*i +: 4] == target_q[4*i +: 4]) begin
                hits_c = hits_c + 3'd1;
            end
        end
    end

    // State register
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (log_out) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (target_valid) state_next = ARMED;
                ARMED: begin
                    if (!target_valid)  state_next = IDLE;
                    else if (rise_q)    state_next = COMPARE;
                end
                COMPARE: state_next = RESULT;
                RESULT: begin
                    if (timer_done_c) begin
                        if (attempts_left == 3'd0) state_next = LOCK;
                        else if (target_valid)     state_next = ARMED;
                        else                       state_next = IDLE;
                    end
                end
                LOCK:    if (timer_done_c) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output and datapath next values
    always_comb begin
        entry_d    = entry_q;
        target_d   = target_q;
        timer_d    = timer;
        match_d    = match;
        mismatch_d = mismatch;
        digits_d   = digits_correct;
        attempts_d = attempts_left;
        locked_d   = locked;
        score_d    = score;
        clear_req  = 1'b0;
        next_d     = 1'b0;

        if (log_out) begin
            timer_d    = '0;
            match_d    = 1'b0;
            mismatch_d = 1'b0;
            digits_d   = 3'd0;
            attempts_d = ATTEMPTS_FULL;
            locked_d   = 1'b0;
            score_d    = '0;
            clear_req  = ~log_q;
        end else begin
            case (state)
                IDLE: clear_req = rise_q;
                ARMED: begin
                    if (!target_valid) begin
                        clear_req = rise_q;
                    end else if (rise_q) begin
                        entry_d  = entered;
                        target_d = target;
                    end
                end
                COMPARE: begin
                    digits_d  = hits_c;
                    timer_d   = RESULT_LOAD;
                    clear_req = 1'b1;
                    if (pass_c) begin
                        match_d    = 1'b1;
                        next_d     = 1'b1;
                        attempts_d = ATTEMPTS_FULL;
                        score_d    = (score == '1) ? score : score + SCORE_W'(1);
                    end else begin
                        mismatch_d = 1'b1;
                        attempts_d = (attempts_left != 3'd0) ? attempts_left - 3'd1 : 3'd0;
                    end
                end
                RESULT: begin
                    if (timer_done_c) begin
                        match_d    = 1'b0;
                        mismatch_d = 1'b0;
                        digits_d   = 3'd0;
                        if (attempts_left == 3'd0) begin
                            locked_d = 1'b1;
                            timer_d  = LOCK_LOAD;
                        end
                    end else begin
                        timer_d = timer - TIMER_W'(1);
                    end
                end
                LOCK: begin
                    clear_req = rise_q;
                    if (timer_done_c) begin
                        locked_d   = 1'b0;
                        attempts_d = ATTEMPTS_FULL;
                    end else begin
                        timer_d = timer - TIMER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; clear_entry is forced low after any high cycle.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            entry_q        <= '0;
            target_q       <= '0;
            timer          <= '0;
            match          <= 1'b0;
            mismatch       <= 1'b0;
            digits_correct <= 3'd0;
            attempts_left  <= ATTEMPTS_FULL;
            locked         <= 1'b0;
            score          <= '0;
            clear_entry    <= 1'b0;
            next_pattern   <= 1'b0;
        end else begin
            entry_q        <= entry_d;
            target_q       <= target_d;
            timer          <= timer_d;
            match          <= match_d;
            mismatch       <= mismatch_d;
            digits_correct <= digits_d;
            attempts_left  <= attempts_d;
            locked         <= locked_d;
            score          <= score_d;
            clear_entry    <= clear_req & ~clear_entry;
            next_pattern   <= next_d & ~next_pattern;
        end
    end

endmodule

// File: doc/entry_checker.md
Name: entry_checker

Overview:
- Sits downstream of the 4-nibble entry shift register in the memory tester game.
- Consumes the assembled 16-bit entry and its valid flag, and compares the entry against the target sequence supplied by the pattern source.
- Scores correct recalls, counts failed attempts and locks the player out after too many misses.
- Drives a clear pulse back to the shift register after every judged entry.

Parameters:
- MAX_ATTEMPTS, 3, failed entries allowed before lockout (1..7).
- LOCK_CYCLES, 50, clock cycles spent in lockout (≥1).
- RESULT_CYCLES, 8, cycles the match/mismatch indication is held (≥1).
- SCORE_W, 8, width of the score counter.

Ports:
- clock  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- entered  in  16  assembled entry; nibble 3 is [15:12] (first entered), nibble 0 is [3:0].
- valid_bit  in  1  level; high while entered holds a complete 4-nibble entry.
- target  in  16  sequence to match, same nibble order.
- target_valid  in  1  level; target is stable and usable.
- log_out  in  1  player abort/log-out request.
- match  out  1  entry equal to target; held RESULT_CYCLES.
- mismatch  out  1  entry differs from target; held RESULT_CYCLES.
- digits_correct  out  3  count of nibble positions equal (0..4); valid while match|mismatch.
- attempts_left  out  3  remaining failures before lockout.
- locked  out  1  high during lockout.
- score  out  SCORE_W  correct-entry count.
- clear_entry  out  1  one-cycle pulse telling the shift register to discard its entry.
- next_pattern  out  1  one-cycle pulse requesting a new target after a pass.

Behaviour:
- Reset values (rst=0, immediate): state IDLE; all outputs 0 except attempts_left=MAX_ATTEMPTS.
- Rising-edge detect on valid_bit using a registered copy; only a 0→1 transition starts a judgement.
- States and transitions:
  - IDLE: go to ARMED when target_valid=1.
  - ARMED: on a valid_bit rise, capture entered and target into registers and go to COMPARE. If target_valid drops, return to IDLE. A valid_bit rise in IDLE only pulses clear_entry and is not judged.
  - COMPARE (1 cycle): compute equality and digits_correct from the captured registers.
    - On a pass: match=1, score+1 (saturates at all-ones), attempts_left reloads to MAX_ATTEMPTS, clear_entry and next_pattern pulse. Go to RESULT.
    - On a fail: mismatch=1, attempts_left−1, clear_entry pulses. Go to RESULT.
  - RESULT: hold match/mismatch/digits_correct for exactly RESULT_CYCLES cycles counted from the first cycle they are high.
    - Then clear them.
    - If attempts_left=0, go to LOCK; otherwise go to ARMED (or IDLE if target_valid=0).
    - valid_bit rises during RESULT are ignored; no clear_entry is issued.
  - LOCK: locked=1 for exactly LOCK_CYCLES cycles. Then locked=0, attempts_left reloads to MAX_ATTEMPTS, go to IDLE. Entries during LOCK get a clear_entry pulse and are not judged.
- Latency: match/mismatch first high 2 cycles after the clock edge that samples valid_bit high (edge-detect register, then COMPARE). clear_entry and next_pattern pulse on the same cycle match/mismatch first rise.
- log_out=1 in any state, synchronous: next state IDLE.
  - score=0, attempts_left=MAX_ATTEMPTS.
  - locked, match, mismatch and digits_correct cleared; timers cleared.
  - clear_entry pulses once.
  - Wins over a simultaneous valid_bit rise.
  - Holding log_out high keeps the block in IDLE and pulses clear_entry only on the first cycle.
- Reset asserted mid-judgement or mid-lock aborts immediately to reset values.
- clear_entry and next_pattern are never high for more than one consecutive cycle.

Test Plan:
- Reset, target_valid=1, target=16'h1234, entry 16'h1234 with valid_bit rising → match=1 two cycles later for 8 cycles, digits_correct=4, score=1, clear_entry and next_pattern pulse once, attempts_left=3.
- Target 16'h1234, entries 16'h1235, 16'h0000, 16'h4321 (each after the result window) → mismatch each time with digits_correct=3, 0, 0; attempts_left 2, 1, 0; then locked=1 for exactly 50 cycles; then attempts_left=3 and the block is in IDLE.
- During lock, valid_bit rise with entered=16'h1234 → clear_entry pulse, no match, score unchanged.
- After score=2 and one miss, log_out pulse coincident with a valid_bit rise → no judgement, score=0, attempts_left=3, single clear_entry pulse.
- SCORE_W=2, five consecutive correct entries → score 1, 2, 3, 3, 3 (saturates).
- rst driven low during the RESULT window of a match → all outputs to reset values immediately; after release, a fresh correct entry gives score=1.
